// File: rtl/reu_regs.sv
// REU register file: decodes the $DF00-$DF1F window and holds command/status/mask
// registers plus working and shadow C64 address, REU address and length counters.
module reu_regs #(
  parameter int unsigned REU_AW   = 19,
  parameter bit          SIZE_BIT = 1'b1
) (
  input  logic        PHI2,
  input  logic        nRESET,
  input  logic        IOSel,
  input  logic        RW,
  input  logic [4:0]  A,
  input  logic [7:0]  Din,
  output logic [7:0]  Dout,
  output logic        DoutEn,
  input  logic        FF00Wr,
  output logic        Execute,
  output logic [1:0]  XferType,
  output logic        Length1,
  output logic [15:0] CA,
  output logic [23:0] REUA,
  input  logic        IncCA,
  input  logic        DecLen,
  input  logic        IncREUA,
  input  logic        XferEnd,
  input  logic        SetEndOfBlock,
  input  logic        SetVerifyErr,
  output logic        nIRQ
);

  // REU address bits above the implemented width are held at 1 in every copy.
  localparam logic [23:0] REUA_HI = ~((24'd1 << REU_AW) - 24'd1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_EXEC
  } xfer_state_t;

  xfer_state_t state, state_next;

  logic        cmd_exec, cmd_auto, cmd_ff00dis;
  logic [1:0]  xfer_type;
  logic        irq, eob, fault;
  logic        irq_next, eob_next, fault_next;
  logic        mask_en, mask_eob, mask_fault;
  logic        fix_ca, fix_reua;
  logic [15:0] ca, ca_sh;
  logic [23:0] reua, reua_sh;
  logic [15:0] len, len_sh;

  logic exec, wr_en, cmd_wr, rd_status;

  assign exec      = (state == ST_EXEC);
  assign wr_en     = IOSel && !RW && !exec;
  assign cmd_wr    = wr_en && (A == 5'd1);
  assign rd_status = IOSel && RW && (A == 5'd0) && !exec;

  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_ARMED: begin
        if (cmd_wr) begin
          if (!Din[7])     state_next = ST_IDLE;
          else if (Din[4]) state_next = ST_EXEC;
          else             state_next = ST_ARMED;
        end else if ((state == ST_ARMED) && FF00Wr) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: if (XferEnd) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Set strobes beat a same-cycle status-read clear; IRQ follows the new flags.
  always_comb begin
    eob_next   = SetEndOfBlock || (eob && !rd_status);
    fault_next = SetVerifyErr || (fault && !rd_status);
    irq_next   = mask_en && ((mask_eob && eob_next) || (mask_fault && fault_next));
  end

  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      irq   <= 1'b0;
      eob   <= 1'b0;
      fault <= 1'b0;
    end else begin
      irq   <= irq_next;
      eob   <= eob_next;
      fault <= fault_next;
    end
  end

  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      cmd_exec    <= 1'b0;
      cmd_auto    <= 1'b0;
      cmd_ff00dis <= 1'b1;
      xfer_type   <= '0;
      mask_en     <= 1'b0;
      mask_eob    <= 1'b0;
      mask_fault  <= 1'b0;
      fix_ca      <= 1'b0;
      fix_reua    <= 1'b0;
    end else if (XferEnd) begin
      cmd_exec    <= 1'b0;
      cmd_ff00dis <= 1'b1;
    end else if (wr_en) begin
      case (A)
        5'd1: begin
          cmd_exec    <= Din[7];
          cmd_auto    <= Din[5];
          cmd_ff00dis <= Din[4];
          xfer_type   <= Din[1:0];
        end
        5'd9: begin
          mask_en    <= Din[7];
          mask_eob   <= Din[6];
          mask_fault <= Din[5];
        end
        5'd10: begin
          fix_ca   <= Din[7];
          fix_reua <= Din[6];
        end
        default: ;
      endcase
    end
  end

  // Autoload takes priority so a same-edge increment cannot leak into the reload.
  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      ca      <= '0;
      ca_sh   <= '0;
      reua    <= REUA_HI;
      reua_sh <= REUA_HI;
      len     <= '1;
      len_sh  <= '1;
    end else if (XferEnd && cmd_auto) begin
      ca   <= ca_sh;
      reua <= reua_sh;
      len  <= len_sh;
    end else if (exec) begin
      if (IncCA && !fix_ca)     ca   <= ca + 16'd1;
      if (IncREUA && !fix_reua) reua <= (reua + 24'd1) | REUA_HI;
      if (DecLen)               len  <= len - 16'd1;
    end else if (wr_en) begin
      case (A)
        5'd2: begin ca[7:0]   <= Din; ca_sh[7:0]   <= Din; end
        5'd3: begin ca[15:8]  <= Din; ca_sh[15:8]  <= Din; end
        5'd4: begin reua[7:0] <= Din; reua_sh[7:0] <= Din; end
        5'd5: begin reua[15:8] <= Din; reua_sh[15:8] <= Din; end
        5'd6: begin
          reua[23:16]    <= Din | REUA_HI[23:16];
          reua_sh[23:16] <= Din | REUA_HI[23:16];
        end
        5'd7: begin len[7:0]  <= Din; len_sh[7:0]  <= Din; end
        5'd8: begin len[15:8] <= Din; len_sh[15:8] <= Din; end
        default: ;
      endcase
    end
  end

  always_comb begin
    Dout = 8'hFF;
    case (A)
      5'd0:  Dout = {irq, eob, fault, SIZE_BIT, 4'h0};
      5'd1:  Dout = {cmd_exec, 1'b1, cmd_auto, cmd_ff00dis, 2'b11, xfer_type};
      5'd2:  Dout = ca[7:0];
      5'd3:  Dout = ca[15:8];
      5'd4:  Dout = reua[7:0];
      5'd5:  Dout = reua[15:8];
      5'd6:  Dout = reua[23:16];
      5'd7:  Dout = len[7:0];
      5'd8:  Dout = len[15:8];
      5'd9:  Dout = {mask_en, mask_eob, mask_fault, 5'h1F};
      5'd10: Dout = {fix_ca, fix_reua, 6'h3F};
      default: Dout = 8'hFF;
    endcase
  end

  assign DoutEn   = IOSel && RW && !exec;
  assign Execute  = exec;
  assign XferType = xfer_type;
  assign Length1  = (len == 16'd1);
  assign CA       = ca;
  assign REUA     = reua;
  assign nIRQ     = !irq;

endmodule
